// File: rtl/sync_fifo_prog_if.sv
// Handshake and status bundle for sync_fifo_prog.
// The producer/consumer side uses master; the FIFO uses slave.
interface sync_fifo_prog_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             wr_en;
  logic [WIDTH-1:0] din;
  logic             rd_en;
  logic [WIDTH-1:0] dout;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             err_clr;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr_en, din, rd_en, err_clr,
    input  dout, rd_valid, full, empty,
    input  almost_full, almost_empty,
    input  count, overflow, underflow
  );

  modport slave (
    input  wr_en, din, rd_en, err_clr,
    output dout, rd_valid, full, empty,
    output almost_full, almost_empty,
    output count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO: programmable almost flags, count, optional FWFT.
// Define SYNC_FIFO_PROG_ERR_EN to build sticky overflow/underflow flags.
module sync_fifo_prog #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input logic            clk,
  input logic            rst_n,
  sync_fifo_prog_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C = CW'(AE_THRESH);

  if (WIDTH < 1 || DEPTH < 2 ||
      AF_THRESH < 1 || AF_THRESH > DEPTH ||
      AE_THRESH < 0 || AE_THRESH > DEPTH - 1 ||
      (FWFT != 0 && FWFT != 1)) begin : g_bad_param
    $error("sync_fifo_prog: illegal parameters");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count_q;
  logic             empty;
  logic             full;
  logic             rd_acc;
  logic             wr_acc;

  assign empty  = (count_q == '0);
  assign full   = (count_q == FULL_C);
  assign rd_acc = bus.rd_en & ~empty;
  assign wr_acc = bus.wr_en & (~full | rd_acc);

  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.almost_empty = (count_q <= AE_C);
  assign bus.count        = count_q;

  // Storage is not reset; the pointers alone define what is readable.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr] <= bus.din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) wptr <= (wptr == LAST) ? '0 : wptr + AW'(1);
      if (rd_acc) rptr <= (rptr == LAST) ? '0 : rptr + AW'(1);
      unique case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign bus.dout     = mem[rptr];
    assign bus.rd_valid = ~empty;
  end else begin : g_reg
    logic [WIDTH-1:0] dout_q;
    logic             valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_acc;
        if (rd_acc) dout_q <= mem[rptr];
      end
    end

    assign bus.dout     = dout_q;
    assign bus.rd_valid = valid_q;
  end

`ifdef SYNC_FIFO_PROG_ERR_EN
  logic ovf_q;
  logic unf_q;

  // A new error in the same cycle as err_clr takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (bus.wr_en & ~wr_acc) ovf_q <= 1'b1;
      else if (bus.err_clr)    ovf_q <= 1'b0;
      if (bus.rd_en & empty)   unf_q <= 1'b1;
      else if (bus.err_clr)    unf_q <= 1'b0;
    end
  end

  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = bus.err_clr;
  assign bus.overflow   = 1'b0;
  assign bus.underflow  = 1'b0;
`endif
endmodule
